// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core and an
// external requester (debug / loader / DMA).
//
// The core has default priority and a purely combinational path to memory, so
// its single-cycle load/store timing is unchanged. An external request is
// granted when the core is idle, or after it has been held off for
// STARVE_LIMIT contended cycles. A granted external access takes the port for
// exactly one cycle (EXT_ACC); the core is stalled during that cycle only.
//
// Optional build macro DMEM_ARB_STATS_EN adds two 16-bit wrapping counters:
// ext_grant_cnt (external grants) and stall_cnt (cycles the core was stalled).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | core owns the port; external request arbitrated here
// EXT_ACC  | external requester owns the port for one access; core stalled
// EXT_DONE | core owns the port; ext_ack high; ext_req ignored this cycle

module dmem_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 6,
    parameter int STARVE_LIMIT = 4     // 1..255
) (
    input  logic          clk,
    input  logic          rst,         // asynchronous, active-low
    // core side
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wd,
    output logic [DW-1:0] core_rd,
    output logic          core_stall,
    // external side
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wd,
    output logic [DW-1:0] ext_rd,
    output logic          ext_ack,
    // memory side
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   ext_grant_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXT_ACC  = 2'd1,
        EXT_DONE = 2'd2
    } state_t;

    // Saturation point of the starvation counter, sized to hold 1..255.
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          ext_ack_q, ext_ack_d;
    logic [DW-1:0] ext_rd_q, ext_rd_d;
    logic          sel_ext;

    // Next-state, starvation counter and registered external response.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ext_ack_d    = 1'b0;
        ext_rd_d     = ext_rd_q;
        case (state_q)
            IDLE: begin
                if (ext_req) begin
                    if (!core_req || (starve_cnt_q == STARVE_MAX)) begin
                        state_d      = EXT_ACC;
                        starve_cnt_d = 8'd0;
                    end else begin
                        // Contended and below the limit, so no overflow here.
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end
                end else begin
                    starve_cnt_d = 8'd0;
                end
            end
            EXT_ACC: begin
                // Read data is captured on writes too; it is the pre-write
                // content of the addressed word.
                ext_rd_d  = mem_q;
                ext_ack_d = 1'b1;
                state_d   = EXT_DONE;
            end
            EXT_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 8'd0;
            ext_ack_q    <= 1'b0;
            ext_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ext_ack_q    <= ext_ack_d;
            ext_rd_q     <= ext_rd_d;
        end
    end

    // Port mux: core passes straight through except during EXT_ACC. mem_we is
    // gated by rst so a write cannot be in progress while reset is asserted.
    always_comb begin
        sel_ext    = (state_q == EXT_ACC);
        mem_a      = sel_ext ? ext_addr : core_addr;
        mem_d      = sel_ext ? ext_wd   : core_wd;
        mem_we     = rst && (sel_ext ? ext_we : (core_req && core_we));
        core_stall = sel_ext && core_req;
        core_rd    = mem_q;
    end

    assign ext_ack = ext_ack_q;
    assign ext_rd  = ext_rd_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] ext_grant_cnt_q, ext_grant_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        grant;

    // Grant and stall event counters; both wrap at 16 bits.
    always_comb begin
        grant           = (state_q == IDLE) && (state_d == EXT_ACC);
        ext_grant_cnt_d = grant      ? ext_grant_cnt_q + 16'd1 : ext_grant_cnt_q;
        stall_cnt_d     = core_stall ? stall_cnt_q + 16'd1     : stall_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_grant_cnt_q <= 16'd0;
            stall_cnt_q     <= 16'd0;
        end else begin
            ext_grant_cnt_q <= ext_grant_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign ext_grant_cnt = ext_grant_cnt_q;
    assign stall_cnt     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors, expected read data queued at
// issue time and compared by a monitor when the DUT presents it.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SL = 4;

    logic          clk;
    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wd, core_rd;
    logic          core_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wd, ext_rd;
    logic          ext_ack;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_q;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   ext_grant_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ext_exp_q [$];
    logic [DW-1:0] core_exp_q [$];

    dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(SL)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wd     (ext_wd),
        .ext_rd     (ext_rd),
        .ext_ack    (ext_ack),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
`ifdef DMEM_ARB_STATS_EN
        ,
        .ext_grant_cnt (ext_grant_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // Data memory: synchronous write, asynchronous read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
    assign mem_q = mem[mem_a];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare registered ext read data on ack and core read data on
    // every unstalled core read.
    always @(negedge clk) begin
        if (ext_ack) begin
            if (ext_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ext_ack_unexpected: got ack with ext_rd 0x%0h expected no ack", ext_rd);
            end else begin
                check("ext_rd", ext_rd, ext_exp_q.pop_front());
            end
        end
        if (rst && core_req && !core_we && !core_stall) begin
            if (core_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL core_rd_unexpected: got read 0x%0h expected none", core_rd);
            end else begin
                check("core_rd", core_rd, core_exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wd = d;
    endtask

    task automatic core_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = a;
        core_exp_q.push_back(exp);
    endtask

    task automatic core_idle();
        tick();
        core_req = 1'b0; core_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wd = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wd = '0;

        // Reset with a core write presented: mem_we must be held low.
        #3 rst = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 6'd5; core_wd = 32'h55;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_ext_ack", ext_ack, 0);
        check("rst_ext_rd", ext_rd, 0);
        check("rst_core_stall", core_stall, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_mem_we", mem_we, 0);
        core_req = 1'b0; core_we = 1'b0;
        #2 rst = 1'b1;

        // Core write passes through in the same cycle.
        core_write(6'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("cw_mem_we", mem_we, 1);
        check("cw_mem_a", mem_a, 5);
        check("cw_mem_d", mem_d, 32'hDEADBEEF);
        check("cw_stall", core_stall, 0);
        core_read(6'd5, 32'hDEADBEEF);

        core_write(6'd9, 32'h12345678);
        core_write(6'd3, 32'h11111111);
        core_write(6'd4, 32'h0);
        core_idle();

        // External read with the core idle.
        tick();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd9;
        ext_exp_q.push_back(32'h12345678);
        @(negedge clk);
        check("er_c0_ack", ext_ack, 0);
        tick();
        @(negedge clk);
        check("er_c1_mem_a", mem_a, 9);
        check("er_c1_mem_we", mem_we, 0);
        check("er_c1_ack", ext_ack, 0);
        tick();
        @(negedge clk);
        check("er_c2_ack", ext_ack, 1);
        check("er_c2_rd", ext_rd, 32'h12345678);
        tick();
        ext_req = 1'b0;
        @(negedge clk);
        check("er_c3_ack", ext_ack, 0);

        // Contention: grant forced after STARVE_LIMIT cycles.
        tick();
        core_req = 1'b1; core_we = 1'b1; core_addr = 6'd6; core_wd = 32'h77;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd5;
        ext_exp_q.push_back(32'hDEADBEEF);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("ct_c%0d_stall", c), core_stall, (c == 5) ? 1 : 0);
            check($sformatf("ct_c%0d_ack", c), ext_ack, (c == 6) ? 1 : 0);
            check($sformatf("ct_c%0d_mem_we", c), mem_we, (c == 5) ? 0 : 1);
            if (c == 5) check("ct_c5_mem_a", mem_a, 5);
            tick();
            if (c == 5) ext_req = 1'b0;
        end
        core_req = 1'b0; core_we = 1'b0;
        core_read(6'd6, 32'h77);
        core_idle();

        // External write while the core has a write pending.
        tick();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 6'd3; ext_wd = 32'hA5A5A5A5;
        ext_exp_q.push_back(32'h11111111);
        @(negedge clk);
        check("ew_c0_ack", ext_ack, 0);
        tick();
        core_req = 1'b1; core_we = 1'b1; core_addr = 6'd4; core_wd = 32'h1;
        @(negedge clk);
        check("ew_c1_stall", core_stall, 1);
        check("ew_c1_mem_we", mem_we, 1);
        check("ew_c1_mem_a", mem_a, 3);
        check("ew_c1_mem_d", mem_d, 32'hA5A5A5A5);
        tick();
        ext_req = 1'b0; ext_we = 1'b0;
        @(negedge clk);
        check("ew_c2_stall", core_stall, 0);
        check("ew_c2_ack", ext_ack, 1);
        check("ew_c2_mem_a", mem_a, 4);
        check("ew_c2_mem_d", mem_d, 32'h1);
        check("ew_c2_mem_we", mem_we, 1);
        core_idle();
        core_read(6'd3, 32'hA5A5A5A5);
        core_read(6'd4, 32'h1);
        core_idle();
`ifdef DMEM_ARB_STATS_EN
        check("st_grants", ext_grant_cnt, 3);
        check("st_stalls", stall_cnt, 2);
`endif

        // Reset in the middle of an external write.
        tick();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 6'd7; ext_wd = 32'hCAFE;
        @(negedge clk);
        check("ra_c0_ack", ext_ack, 0);
        tick();
        @(negedge clk);
        check("ra_c1_mem_we", mem_we, 1);
        #2 rst = 1'b0;
        #1;
        check("ra_rst_mem_we", mem_we, 0);
        ext_req = 1'b0; ext_we = 1'b0;
        @(negedge clk);
        check("ra_rst_ack", ext_ack, 0);
`ifdef DMEM_ARB_STATS_EN
        check("ra_grants_zero", ext_grant_cnt, 0);
        check("ra_stalls_zero", stall_cnt, 0);
`endif
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("ra_post_c%0d_ack", c), ext_ack, 0);
        end
        core_write(6'd8, 32'h42);
        @(negedge clk);
        check("ra_idle_mem_a", mem_a, 8);
        check("ra_idle_mem_we", mem_we, 1);
        check("ra_idle_stall", core_stall, 0);
        core_read(6'd8, 32'h42);
        core_idle();

        repeat (2) tick();
        check("ext_queue_empty", ext_exp_q.size(), 0);
        check("core_queue_empty", core_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
